// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and load funct3 encodings.
// Imported by the writeback stage and its load-return queue.
package core_pkg;

  localparam int XLEN           = 64;
  localparam int REG_ADDR_WIDTH = 5;

  // Load types as encoded in funct3; 3'b111 is reserved.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

endpackage

// File: rtl/wb_lq_fifo.sv
// Synchronous FIFO holding pending load returns as packed {rd, data} entries.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_lq_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates EX results against queued LSU load returns and
// drives the single registered register-file write port.
module wb_stage #(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int ADDR_W   = core_pkg::REG_ADDR_WIDTH,
  parameter int LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic [2:0]        lsu_funct3,
  input  logic [2:0]        lsu_off,
  output logic              alu_stall,
  output logic              lq_empty,
  output logic              rd_wen,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data,
  output logic              proto_err
);

  import core_pkg::*;

  localparam int CNT_W   = $clog2(LQ_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + XLEN;

  // Lane selection uses only the low-order offset bits that matter for each size.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0]      funct3,
                                                  input logic [2:0]      off,
                                                  input logic [XLEN-1:0] dword);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = dword[{off, 3'b000} +: 8];
    h = dword[{off[2:1], 4'b0000} +: 16];
    w = dword[{off[2], 5'b00000} +: 32];
    case (funct3)
      LB:      load_extend = {{(XLEN-8){b[7]}}, b};
      LH:      load_extend = {{(XLEN-16){h[15]}}, h};
      LW:      load_extend = {{(XLEN-32){w[31]}}, w};
      LD:      load_extend = dword;
      LBU:     load_extend = {{(XLEN-8){1'b0}}, b};
      LHU:     load_extend = {{(XLEN-16){1'b0}}, h};
      LWU:     load_extend = {{(XLEN-32){1'b0}}, w};
      default: load_extend = '0;
    endcase
  endfunction

  logic               rst_sync_q;
  logic [CNT_W-1:0]   lq_count;
  logic               lq_full;
  logic               lq_push;
  logic               lq_pop;
  logic               alu_sel;
  logic [ENTRY_W-1:0] lq_head;
  logic [ADDR_W-1:0]  head_rd;
  logic [XLEN-1:0]    head_data;

  // lsu_ready is held low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  // Ready and stall come from the registered count only: no same-cycle pop credit.
  assign lsu_ready = rst_sync_q && (lq_count < CNT_W'(LQ_DEPTH));
  assign alu_stall = lq_full;

  // Loads to x0 complete the handshake but never occupy a queue slot.
  assign lq_push = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign alu_sel = alu_valid && (alu_rd != '0) && !alu_stall;
  assign lq_pop  = !alu_sel && !lq_empty;

  assign {head_rd, head_data} = lq_head;

  wb_lq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lq_push),
    .push_data ({lsu_rd, load_extend(lsu_funct3, lsu_off, lsu_data)}),
    .pop       (lq_pop),
    .pop_data  (lq_head),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  // Address/data hold their last written value; only rd_wen pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wen    <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      proto_err <= 1'b0;
    end else begin
      rd_wen <= alu_sel || lq_pop;
      if (alu_sel) begin
        rd_addr <= alu_rd;
        rd_data <= alu_data;
      end else if (lq_pop) begin
        rd_addr <= head_rd;
        rd_data <= head_data;
      end
      if (alu_valid && alu_stall) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven load extension vectors plus
// directed sequences for arbitration, full queue, x0, protocol error and reset.
module tb_wb_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic [2:0]  lsu_funct3;
  logic [2:0]  lsu_off;
  logic        alu_stall;
  logic        lq_empty;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        proto_err;

  wb_stage #(.XLEN(64), .ADDR_W(5), .LQ_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_funct3 (lsu_funct3),
    .lsu_off    (lsu_off),
    .alu_stall  (alu_stall),
    .lq_empty   (lq_empty),
    .rd_wen     (rd_wen),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_idle();
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    lsu_valid  = 1'b0;
    lsu_rd     = '0;
    lsu_data   = '0;
    lsu_funct3 = 3'(LD);
    lsu_off    = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [63:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [2:0] off, input logic [63:0] data);
    lsu_valid  = 1'b1;
    lsu_rd     = rd;
    lsu_funct3 = f3;
    lsu_off    = off;
    lsu_data   = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_wen"},    64'(rd_wen),    64'd0);
    check({tag, "_rd_addr"},   64'(rd_addr),   64'd0);
    check({tag, "_rd_data"},   rd_data,        64'd0);
    check({tag, "_lsu_ready"}, 64'(lsu_ready), 64'd0);
    check({tag, "_alu_stall"}, 64'(alu_stall), 64'd0);
    check({tag, "_lq_empty"},  64'(lq_empty),  64'd1);
    check({tag, "_proto_err"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    logic stale;
    int   n;

    vecs[0]  = '{3'(LB),  3'd3, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80};
    vecs[1]  = '{3'(LBU), 3'd3, 64'h00000000_80000000, 64'h00000000_00000080};
    vecs[2]  = '{3'(LW),  3'd4, 64'hF0000000_00000000, 64'hFFFFFFFF_F0000000};
    vecs[3]  = '{3'(LWU), 3'd4, 64'hF0000000_00000000, 64'h00000000_F0000000};
    vecs[4]  = '{3'(LH),  3'd6, 64'h80010000_00000000, 64'hFFFFFFFF_FFFF8001};
    vecs[5]  = '{3'(LHU), 3'd2, 64'h00000000_ABCD0000, 64'h00000000_0000ABCD};
    vecs[6]  = '{3'(LD),  3'd0, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF};
    vecs[7]  = '{3'b111,  3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000000};
    vecs[8]  = '{3'(LH),  3'd3, 64'h00000000_12345678, 64'h00000000_00001234};
    vecs[9]  = '{3'(LB),  3'd0, 64'h00000000_0000007F, 64'h00000000_0000007F};
    vecs[10] = '{3'(LBU), 3'd7, 64'hFF000000_00000000, 64'h00000000_000000FF};

    // Reset: create a real falling edge, then check idle outputs.
    drive_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1 check("ready_before_edge", 64'(lsu_ready), 64'd0);
    @(negedge clk);
    check("ready_after_edge", 64'(lsu_ready), 64'd1);

    // Load extension vectors; each runs alone so the write lands exactly two cycles later.
    for (int i = 0; i < 11; i++) begin
      check($sformatf("v%0d_ready", i), 64'(lsu_ready), 64'd1);
      drive_load(5'(i + 1), vecs[i].f3, vecs[i].off, vecs[i].data);
      @(negedge clk);
      drive_idle();
      check($sformatf("v%0d_not_early", i), 64'(rd_wen), 64'd0);
      n = 1;
      while (!rd_wen && n < 8) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("v%0d_latency", i), 64'(n), 64'd2);
      check($sformatf("v%0d_wen", i), 64'(rd_wen), 64'd1);
      check($sformatf("v%0d_addr", i), 64'(rd_addr), 64'(i + 1));
      check($sformatf("v%0d_data", i), rd_data, vecs[i].exp);
      @(negedge clk);
    end

    // ALU write: present at N, visible at N+1, pulse gone at N+2 with address held.
    drive_alu(5'd5, 64'h1234);
    @(negedge clk);
    drive_idle();
    check("alu_wen", 64'(rd_wen), 64'd1);
    check("alu_addr", 64'(rd_addr), 64'd5);
    check("alu_data", rd_data, 64'h1234);
    @(negedge clk);
    check("alu_wen_pulse", 64'(rd_wen), 64'd0);
    check("alu_addr_held", 64'(rd_addr), 64'd5);

    // Arbitration: load x7 accepted at N, ALU x3 at N+1 and N+2, load drains after.
    drive_load(5'd7, 3'(LD), 3'd0, 64'h77);
    @(negedge clk);
    drive_idle();
    drive_alu(5'd3, 64'h33);
    @(negedge clk);
    check("arb_x3a_addr", 64'(rd_addr), 64'd3);
    check("arb_x3a_data", rd_data, 64'h33);
    check("arb_lq_pending", 64'(lq_empty), 64'd0);
    drive_alu(5'd3, 64'h34);
    @(negedge clk);
    drive_idle();
    check("arb_x3b_data", rd_data, 64'h34);
    @(negedge clk);
    check("arb_x7_wen", 64'(rd_wen), 64'd1);
    check("arb_x7_addr", 64'(rd_addr), 64'd7);
    check("arb_x7_data", rd_data, 64'h77);
    check("arb_lq_empty", 64'(lq_empty), 64'd1);

    // Full queue: two loads under ALU traffic, a third held while full.
    drive_alu(5'd9, 64'h91);
    drive_load(5'd10, 3'(LD), 3'd0, 64'hA);
    @(negedge clk);
    check("full_ready_one", 64'(lsu_ready), 64'd1);
    drive_alu(5'd9, 64'h92);
    drive_load(5'd11, 3'(LD), 3'd0, 64'hB);
    @(negedge clk);
    check("full_ready_low", 64'(lsu_ready), 64'd0);
    check("full_stall_high", 64'(alu_stall), 64'd1);
    check("full_alu_data", rd_data, 64'h92);
    alu_valid = 1'b0;
    drive_load(5'd12, 3'(LD), 3'd0, 64'hC);
    @(negedge clk);
    check("drain0_addr", 64'(rd_addr), 64'd10);
    check("drain0_data", rd_data, 64'hA);
    check("drain_stall_low", 64'(alu_stall), 64'd0);
    check("drain_ready_back", 64'(lsu_ready), 64'd1);
    @(negedge clk);
    lsu_valid = 1'b0;
    check("drain1_addr", 64'(rd_addr), 64'd11);
    check("drain1_data", rd_data, 64'hB);
    @(negedge clk);
    check("drain2_addr", 64'(rd_addr), 64'd12);
    check("drain2_data", rd_data, 64'hC);
    check("drain_lq_empty", 64'(lq_empty), 64'd1);
    @(negedge clk);
    check("drain_idle_wen", 64'(rd_wen), 64'd0);

    // x0: neither source produces a write, queue stays empty.
    drive_alu(5'd0, 64'h55);
    drive_load(5'd0, 3'(LD), 3'd0, 64'h66);
    @(negedge clk);
    drive_idle();
    check("x0_wen", 64'(rd_wen), 64'd0);
    check("x0_lq_empty", 64'(lq_empty), 64'd1);
    @(negedge clk);
    check("x0_wen_late", 64'(rd_wen), 64'd0);
    check("x0_lq_empty_late", 64'(lq_empty), 64'd1);
    check("x0_addr_held", 64'(rd_addr), 64'd12);

    // Protocol error: ALU issues during stall; head wins, ALU result dropped.
    drive_alu(5'd9, 64'h99);
    drive_load(5'd13, 3'(LD), 3'd0, 64'hD13);
    @(negedge clk);
    drive_load(5'd14, 3'(LD), 3'd0, 64'hD14);
    @(negedge clk);
    check("perr_stall", 64'(alu_stall), 64'd1);
    lsu_valid = 1'b0;
    drive_alu(5'd20, 64'hBAD);
    @(negedge clk);
    check("perr_head_addr", 64'(rd_addr), 64'd13);
    check("perr_head_data", rd_data, 64'hD13);
    check("perr_flag", 64'(proto_err), 64'd1);

    // Refill to two entries, then reset mid-operation.
    drive_alu(5'd9, 64'h99);
    drive_load(5'd15, 3'(LD), 3'd0, 64'hD15);
    @(negedge clk);
    drive_idle();
    check("rst_pre_stall", 64'(alu_stall), 64'd1);
    check("rst_pre_wen", 64'(rd_wen), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stale = stale | rd_wen;
    end
    check("post_rst_no_stale", 64'(stale), 64'd0);
    check("post_rst_proto_err", 64'(proto_err), 64'd0);
    check("post_rst_lq_empty", 64'(lq_empty), 64'd1);
    check("post_rst_ready", 64'(lsu_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
